// File: rtl/dram_port_arbiter.sv
// Arbitrates a single-port 32-bit SRAM between a CPU data port and a Wishbone slave port.
// Optional macro DRAM_ARB_WB_PRIORITY_EN: Wishbone wins every tie instead of round-robin.
module dram_port_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [3:0]        cpu_be_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [31:0]       cpu_rdata_o,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              dram_clk0,
  output logic              dram_csb0,
  output logic              dram_web0,
  output logic [3:0]        dram_wmask0,
  output logic [ADDR_W-1:0] dram_addr0,
  output logic [31:0]       dram_din0,
  input  logic [31:0]       dram_dout0
);

  logic wbReq;
  logic cpuWins;
  logic cpuGnt;
  logic wbGnt;

  logic ackPending_q, ackPending_d;
  logic wbWe_q, wbWe_d;
  logic cpuRvalid_q, cpuRvalid_d;
  logic cpuWe_q, cpuWe_d;
`ifdef DRAM_ARB_WB_PRIORITY_EN
`else
  logic lastGrantWb_q, lastGrantWb_d;
`endif

  // Byte offset and bits above the SRAM depth are decoded upstream.
  logic unusedAdrBits;
  assign unusedAdrBits = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

  assign dram_clk0 = clk_i;

  always_comb begin
    wbReq = wbs_cyc_i & wbs_stb_i & ~ackPending_q;
`ifdef DRAM_ARB_WB_PRIORITY_EN
    cpuWins = ~wbReq;
`else
    cpuWins = ~wbReq | lastGrantWb_q;
`endif
    // Reset gates both grants so nothing reaches the SRAM while rstn_i is low.
    cpuGnt = rstn_i & cpu_req_i & cpuWins;
    wbGnt  = rstn_i & wbReq & ~cpuGnt;
  end

  always_comb begin
    dram_csb0   = 1'b1;
    dram_web0   = 1'b1;
    dram_wmask0 = 4'h0;
    dram_addr0  = '0;
    dram_din0   = 32'h0;
    if (cpuGnt) begin
      dram_csb0   = 1'b0;
      dram_web0   = ~cpu_we_i;
      dram_wmask0 = cpu_be_i;
      dram_addr0  = cpu_addr_i;
      dram_din0   = cpu_wdata_i;
    end else if (wbGnt) begin
      dram_csb0   = 1'b0;
      dram_web0   = ~wbs_we_i;
      dram_wmask0 = wbs_sel_i;
      dram_addr0  = wbs_adr_i[ADDR_W+1:2];
      dram_din0   = wbs_dat_i;
    end
  end

  always_comb begin
    ackPending_d = wbGnt;
    wbWe_d       = wbGnt ? wbs_we_i : wbWe_q;
    cpuRvalid_d  = cpuGnt;
    cpuWe_d      = cpuGnt ? cpu_we_i : cpuWe_q;
`ifdef DRAM_ARB_WB_PRIORITY_EN
`else
    lastGrantWb_d = wbGnt ? 1'b1 : (cpuGnt ? 1'b0 : lastGrantWb_q);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ackPending_q  <= 1'b0;
      wbWe_q        <= 1'b0;
      cpuRvalid_q   <= 1'b0;
      cpuWe_q       <= 1'b0;
`ifdef DRAM_ARB_WB_PRIORITY_EN
`else
      lastGrantWb_q <= 1'b0;
`endif
    end else begin
      ackPending_q  <= ackPending_d;
      wbWe_q        <= wbWe_d;
      cpuRvalid_q   <= cpuRvalid_d;
      cpuWe_q       <= cpuWe_d;
`ifdef DRAM_ARB_WB_PRIORITY_EN
`else
      lastGrantWb_q <= lastGrantWb_d;
`endif
    end
  end

  // A response still owed when reset or a WB abort arrives is dropped, never replayed.
  assign wbs_ack_o    = ackPending_q & wbs_cyc_i & rstn_i;
  assign wbs_dat_o    = (wbs_ack_o & ~wbWe_q) ? dram_dout0 : 32'h0;
  assign cpu_gnt_o    = cpuGnt;
  assign cpu_rvalid_o = cpuRvalid_q & rstn_i;
  assign cpu_rdata_o  = (cpu_rvalid_o & ~cpuWe_q) ? dram_dout0 : 32'h0;

endmodule

// File: doc/dram_port_arbiter.md
DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, the DRAM word-address width (512 x 32-bit words).
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge; also driven out unchanged as dram_clk0.
REQ-003 SHALL have port rstn_i, input, 1, the reset: synchronous and active-low.
REQ-004 SHALL have CPU data ports:
- cpu_req_i, cpu_we_i: input, 1.
- cpu_be_i: input, 4.
- cpu_addr_i: input, ADDR_W, word address.
- cpu_wdata_i: input, 32.
- cpu_gnt_o: output, 1, combinational grant.
- cpu_rvalid_o: output, 1.
- cpu_rdata_o: output, 32.
REQ-005 SHALL have Wishbone slave ports:
- wbs_cyc_i, wbs_stb_i, wbs_we_i: input, 1.
- wbs_sel_i: input, 4.
- wbs_adr_i: input, 32, byte address.
- wbs_dat_i: input, 32.
- wbs_ack_o: output, 1.
- wbs_dat_o: output, 32.
REQ-006 SHALL have SRAM port:
- dram_clk0, dram_csb0 (active low), dram_web0 (active low): output, 1.
- dram_wmask0: output, 4.
- dram_addr0: output, ADDR_W.
- dram_din0: output, 32.
- dram_dout0: input, 32, valid the cycle after a read issue.

Function
REQ-007 SHALL define the requests:
- CPU request: cpu_req_i=1.
- WB request: wbs_cyc_i & wbs_stb_i & ~ack_pending, where ack_pending is the internal flag set in the cycle after a WB grant.
REQ-008 SHALL grant at most one requester per cycle. The granted access is driven combinationally onto dram_* in the same cycle:
- dram_csb0=0.
- dram_web0=~we.
- dram_wmask0 = be or sel.
- dram_addr0 = cpu_addr_i or wbs_adr_i[ADDR_W+1:2].
- dram_din0 = wdata or dat.
REQ-009 SHALL, with no grant, drive dram_csb0=1, dram_web0=1, dram_wmask0=0, dram_addr0=0, dram_din0=0.
REQ-010 SHALL assert cpu_gnt_o in the cycle the CPU access is issued, and never when cpu_req_i=0.
REQ-011 SHALL assert cpu_rvalid_o exactly one cycle after every CPU grant (read or write), with cpu_rdata_o=dram_dout0 for reads and 0 for writes.
REQ-012 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a WB grant, with wbs_dat_o=dram_dout0 for reads and 0 for writes. The ack is suppressed if wbs_cyc_i=0 in that cycle; ack_pending still clears.
REQ-013 SHALL allow a CPU grant in the WB ack cycle. A new WB grant is impossible in that cycle, so the minimum WB access spacing is 2 cycles.
REQ-014 SHALL resolve simultaneous CPU and WB requests round-robin: the requester not granted last wins. A single requester always wins. The last_grant register updates on every grant.
REQ-015 SHALL set wbs_dat_o and cpu_rdata_o to 0 whenever their valid/ack is low.
REQ-016 SHALL ignore wbs_adr_i bits above ADDR_W+1 and bits [1:0]. Address decode is done upstream.

Reset
REQ-017 SHALL, while rstn_i=0 at a clock edge, clear ack_pending and cpu_rvalid_o, and set last_grant=CPU, so the first tie goes to WB.
REQ-018 SHALL hold all grants low while rstn_i=0: dram_csb0=1, cpu_gnt_o=0, wbs_ack_o=0. A pending ack or rvalid is dropped, not replayed.

Configuration
REQ-019 SHALL honour macro DRAM_ARB_WB_PRIORITY_EN:
- Defined: WB always wins ties; last_grant is unused.
- Undefined: round-robin per REQ-014.

Verification
REQ-020 WB write then read:
- WB write adr=0x0000_0010, sel=0xF, dat=0xDEADBEEF -> dram_addr0=4, dram_wmask0=0xF, ack next cycle.
- WB read of the same address -> wbs_dat_o=0xDEADBEEF on ack.
REQ-021 CPU read of addr 4 -> cpu_gnt_o same cycle; cpu_rvalid_o next cycle with cpu_rdata_o=0xDEADBEEF.
REQ-022 Tie sequence after reset, CPU and WB requesting together:
- Default build -> grant order WB, CPU (CPU also granted in the WB ack cycle), then WB.
- With DRAM_ARB_WB_PRIORITY_EN -> WB granted every second cycle, CPU only in the ack cycles.
REQ-023 Byte write: CPU be=0x2, wdata=0x0000AB00 to a word holding 0x11223344 -> dram_wmask0=0x2; a later read returns 0x1122AB44.
REQ-024 Reset mid-operation: rstn_i=0 in the cycle after a WB read grant -> wbs_ack_o stays 0; after release, a new WB request is granted on its first cycle.
REQ-025 WB abort: wbs_cyc_i dropped in the ack cycle -> wbs_ack_o=0; the next WB request is granted normally.
